// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_pkg
//  Purpose  : 640x480@60 timing constants, phase encoding and the colour-bar
//             palette shared by the VGA sync generator.
//  Revision : 1.0  initial release
// ============================================================================
package vga_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } vga_phase_t;

    // 4:4:4 palette, R in [11:8], G in [7:4], B in [3:0]
    function automatic logic [11:0] bar_colour(input logic [2:0] idx);
        logic [11:0] col;
        col = 12'h000;
        case (idx)
            3'd0:    col = 12'hFFF;
            3'd1:    col = 12'hFF0;
            3'd2:    col = 12'h0FF;
            3'd3:    col = 12'h0F0;
            3'd4:    col = 12'hF0F;
            3'd5:    col = 12'hF00;
            3'd6:    col = 12'h00F;
            default: col = 12'h000;
        endcase
        return col;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
//  Module   : vga_axis_counter
//  Purpose  : One timing axis: wrapping position counter plus the
//             ACTIVE/FRONT/SYNC/BACK phase machine that tracks it.
//  Revision : 1.0  initial release
// ============================================================================
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE_LEN = 640,
    parameter int FP_LEN     = 16,
    parameter int SYNC_LEN   = 96,
    parameter int BP_LEN     = 48
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    output logic [9:0] o_count,
    output logic       o_wrap,
    output vga_phase_t o_phase
);

    localparam logic [9:0] c_active_last = 10'(ACTIVE_LEN - 1);
    localparam logic [9:0] c_front_last  = 10'(ACTIVE_LEN + FP_LEN - 1);
    localparam logic [9:0] c_sync_last   = 10'(ACTIVE_LEN + FP_LEN + SYNC_LEN - 1);
    localparam logic [9:0] c_total_last  = 10'(ACTIVE_LEN + FP_LEN + SYNC_LEN + BP_LEN - 1);

    logic [9:0] r_count;
    logic [9:0] w_count_next;
    vga_phase_t r_phase;
    vga_phase_t w_phase_next;

    assign o_wrap  = i_en && (r_count == c_total_last);
    assign o_count = r_count;
    assign o_phase = r_phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 10'd0;
            r_phase <= ACTIVE;
        end else begin
            r_count <= w_count_next;
            r_phase <= w_phase_next;
        end
    end

    // Phase changes on the same edge the count crosses into the next region
    always_comb begin
        w_count_next = r_count;
        w_phase_next = r_phase;
        if (i_en) begin
            w_count_next = o_wrap ? 10'd0 : r_count + 10'd1;
            case (r_phase)
                ACTIVE:  if (r_count == c_active_last) w_phase_next = FRONT;
                FRONT:   if (r_count == c_front_last)  w_phase_next = SYNC;
                SYNC:    if (r_count == c_sync_last)   w_phase_next = BACK;
                BACK:    if (r_count == c_total_last)  w_phase_next = ACTIVE;
                default: w_phase_next = ACTIVE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_sync_gen
//  Purpose  : 640x480@60 VGA timing generator with registered sync, video
//             window, pixel coordinates and line/frame strobes.
//             Define VGA_TEST_PATTERN_EN for the 8-bar colour test pattern.
//  Revision : 1.0  initial release
// ============================================================================
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP     = vga_timing_pkg::H_FP,
    parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int H_BP     = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP     = vga_timing_pkg::V_FP,
    parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int V_BP     = vga_timing_pkg::V_BP,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        vgaCLK,
    input  logic        reset,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        line_start,
    output logic        frame_start,
    output logic [11:0] rgb
);

    logic [9:0]  w_h_cnt;
    logic [9:0]  w_v_cnt;
    logic        w_h_wrap;
    logic        w_v_wrap_unused;
    vga_phase_t  w_h_phase;
    vga_phase_t  w_v_phase;
    logic        w_video_next;
    logic [11:0] w_rgb_next;

    logic        r_hsync;
    logic        r_vsync;
    logic        r_video_on;
    logic [9:0]  r_pixel_x;
    logic [9:0]  r_pixel_y;
    logic        r_line_start;
    logic        r_frame_start;
    logic [11:0] r_rgb;

    vga_axis_counter #(
        .ACTIVE_LEN (H_ACTIVE),
        .FP_LEN     (H_FP),
        .SYNC_LEN   (H_SYNC),
        .BP_LEN     (H_BP)
    ) u_h_axis (
        .clk     (vgaCLK),
        .rst     (reset),
        .i_en    (1'b1),
        .o_count (w_h_cnt),
        .o_wrap  (w_h_wrap),
        .o_phase (w_h_phase)
    );

    vga_axis_counter #(
        .ACTIVE_LEN (V_ACTIVE),
        .FP_LEN     (V_FP),
        .SYNC_LEN   (V_SYNC),
        .BP_LEN     (V_BP)
    ) u_v_axis (
        .clk     (vgaCLK),
        .rst     (reset),
        .i_en    (w_h_wrap),
        .o_count (w_v_cnt),
        .o_wrap  (w_v_wrap_unused),
        .o_phase (w_v_phase)
    );

    assign w_video_next = (w_h_phase == ACTIVE) && (w_v_phase == ACTIVE);

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] w_bar;
    assign w_bar      = 3'(w_h_cnt / 10'd80);
    assign w_rgb_next = w_video_next ? bar_colour(w_bar) : 12'h000;
`else
    assign w_rgb_next = 12'h000;
`endif

    // Every output is decoded from the same counter snapshot, one cycle late
    always_ff @(posedge vgaCLK) begin
        if (reset) begin
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_video_on    <= 1'b0;
            r_pixel_x     <= 10'd0;
            r_pixel_y     <= 10'd0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_rgb         <= 12'h000;
        end else begin
            r_hsync       <= (w_h_phase == SYNC) ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= (w_v_phase == SYNC) ? SYNC_POL : ~SYNC_POL;
            r_video_on    <= w_video_next;
            r_pixel_x     <= w_h_cnt;
            r_pixel_y     <= w_v_cnt;
            r_line_start  <= (w_h_cnt == 10'd0);
            r_frame_start <= (w_h_cnt == 10'd0) && (w_v_cnt == 10'd0);
            r_rgb         <= w_rgb_next;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign video_on    = r_video_on;
    assign pixel_x     = r_pixel_x;
    assign pixel_y     = r_pixel_y;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign rgb         = r_rgb;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_sync_gen
//  Purpose  : Self-checking bench for vga_sync_gen: a full-size instance for
//             line timing and pattern, a shrunken instance for frame timing.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_vga_sync_gen;

    localparam int SH_A = 8, SH_F = 2, SH_S = 3, SH_B = 3;
    localparam int SV_A = 6, SV_F = 2, SV_S = 2, SV_B = 3;
    localparam int SH_T = SH_A + SH_F + SH_S + SH_B;
    localparam int SV_T = SV_A + SV_F + SV_S + SV_B;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        von;
        logic [9:0]  px;
        logic [9:0]  py;
        logic        ls;
        logic        fs;
        logic [11:0] rgb;
    } out_t;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic rst0, rst1;
    logic hs0, vs0, von0, ls0, fs0, hs1, vs1, von1, ls1, fs1;
    logic [9:0]  px0, py0, px1, py1;
    logic [11:0] rgb0, rgb1;

    vga_sync_gen u_dut0 (
        .vgaCLK(clk), .reset(rst0), .hsync(hs0), .vsync(vs0), .video_on(von0),
        .pixel_x(px0), .pixel_y(py0), .line_start(ls0), .frame_start(fs0), .rgb(rgb0)
    );

    vga_sync_gen #(
        .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
        .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B), .SYNC_POL(1'b0)
    ) u_dut1 (
        .vgaCLK(clk), .reset(rst1), .hsync(hs1), .vsync(vs1), .video_on(von1),
        .pixel_x(px1), .pixel_y(py1), .line_start(ls1), .frame_start(fs1), .rgb(rgb1)
    );

    int passed = 0, total = 0;
    int mh0 = 0, mv0 = 0, mh1 = 0, mv1 = 0;
    int bad0 = 0, bad1 = 0;
    out_t q0[$], q1[$];
    out_t e0, e1, g0, g1;

    function automatic out_t rst_out();
        out_t o;
        o     = '0;
        o.hs  = 1'b1;
        o.vs  = 1'b1;
        return o;
    endfunction

    // Reference decode straight from the region boundaries (active-low sync)
    function automatic out_t model(input int h, input int v, input int ha, input int hf,
                                   input int hsn, input int va, input int vf, input int vsn);
        out_t o;
        o.hs  = !((h >= ha + hf) && (h < ha + hf + hsn));
        o.vs  = !((v >= va + vf) && (v < va + vf + vsn));
        o.von = (h < ha) && (v < va);
        o.px  = 10'(h);
        o.py  = 10'(v);
        o.ls  = (h == 0);
        o.fs  = (h == 0) && (v == 0);
        o.rgb = 12'h000;
`ifdef VGA_TEST_PATTERN_EN
        if (o.von) begin
            case (h / 80)
                0: o.rgb = 12'hFFF;
                1: o.rgb = 12'hFF0;
                2: o.rgb = 12'h0FF;
                3: o.rgb = 12'h0F0;
                4: o.rgb = 12'hF0F;
                5: o.rgb = 12'hF00;
                6: o.rgb = 12'h00F;
                default: o.rgb = 12'h000;
            endcase
        end
`endif
        return o;
    endfunction

    // One clock: drive resets, push expectations, sample on the falling edge
    task automatic step(input logic r0, input logic r1);
        rst0 = r0;
        rst1 = r1;
        if (r0) begin
            q0.push_back(rst_out()); mh0 = 0; mv0 = 0;
        end else begin
            q0.push_back(model(mh0, mv0, 640, 16, 96, 480, 10, 2));
            mh0++;
            if (mh0 == 800) begin mh0 = 0; mv0 = (mv0 == 524) ? 0 : mv0 + 1; end
        end
        if (r1) begin
            q1.push_back(rst_out()); mh1 = 0; mv1 = 0;
        end else begin
            q1.push_back(model(mh1, mv1, SH_A, SH_F, SH_S, SV_A, SV_F, SV_S));
            mh1++;
            if (mh1 == SH_T) begin mh1 = 0; mv1 = (mv1 == SV_T - 1) ? 0 : mv1 + 1; end
        end
        @(negedge clk);
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        g0 = {hs0, vs0, von0, px0, py0, ls0, fs0, rgb0};
        g1 = {hs1, vs1, von1, px1, py1, ls1, fs1, rgb1};
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1);
            total++;
            if (g0 !== e0) $display("FAIL reset_dut0 cyc%0d got=%h required=%h", i, g0, e0);
            else passed++;
            total++;
            if (g1 !== e1) $display("FAIL reset_dut1 cyc%0d got=%h required=%h", i, g1, e1);
            else passed++;
        end
        total++;
        if ({hs0, vs0, von0, px0, py0, rgb0} !== {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 12'h000})
            $display("FAIL reset_values hs=%b vs=%b von=%b x=%0d y=%0d rgb=%h required 1 1 0 0 0 000",
                     hs0, vs0, von0, px0, py0, rgb0);
        else passed++;
        step(1'b0, 1'b0);
        total++;
        if ({fs0, ls0, von0, px0, py0} !== {1'b1, 1'b1, 1'b1, 10'd0, 10'd0})
            $display("FAIL first_pixel fs=%b ls=%b von=%b x=%0d y=%0d required 1 1 1 0 0",
                     fs0, ls0, von0, px0, py0);
        else passed++;
        total++;
        if (g1 !== e1) $display("FAIL first_pixel_dut1 got=%h required=%h", g1, e1);
        else passed++;
    endtask

    task automatic test_line_timing();
        int last_ls = 0, n_ls = 0, bad_int = 0, hs_low = 0, hs_start = -1, von_n = 0;
        logic prev_hs = 1'b1;
        bad0 = 0; bad1 = 0;
        for (int i = 1; i <= 2400; i++) begin
            step(1'b0, 1'b0);
            if (g0 !== e0) bad0++;
            if (g1 !== e1) bad1++;
            if (ls0) begin
                n_ls++;
                if (i - last_ls != 800) bad_int++;
                last_ls = i;
            end
            if (!hs0) hs_low++;
            if (prev_hs && !hs0 && hs_start < 0) hs_start = int'(px0);
            prev_hs = hs0;
            if (von0) von_n++;
        end
        total++;
        if (n_ls !== 3 || bad_int !== 0)
            $display("FAIL line_period pulses=%0d bad_intervals=%0d required 3 and 0", n_ls, bad_int);
        else passed++;
        total++;
        if (hs_low !== 288) $display("FAIL hsync_width low_cycles=%0d required 288", hs_low);
        else passed++;
        total++;
        if (hs_start !== 656) $display("FAIL hsync_start x=%0d required 656", hs_start);
        else passed++;
        total++;
        if (von_n !== 1920) $display("FAIL active_per_line von_cycles=%0d required 1920", von_n);
        else passed++;
        total++;
        if (bad0 !== 0) $display("FAIL line_stream_dut0 mismatches=%0d required 0", bad0);
        else passed++;
        total++;
        if (bad1 !== 0) $display("FAIL line_stream_dut1 mismatches=%0d required 0", bad1);
        else passed++;
    endtask

    task automatic test_pattern();
        logic [11:0] c79 = 'x, c80 = 'x, c560 = 'x, c700 = 'x;
        logic [11:0] x79, x80, x560;
`ifdef VGA_TEST_PATTERN_EN
        x79 = 12'hFFF; x80 = 12'hFF0; x560 = 12'h000;
`else
        x79 = 12'h000; x80 = 12'h000; x560 = 12'h000;
`endif
        bad0 = 0;
        for (int i = 0; i < 800; i++) begin
            step(1'b0, 1'b0);
            if (g0 !== e0) bad0++;
            if (px0 == 10'd79)  c79  = rgb0;
            if (px0 == 10'd80)  c80  = rgb0;
            if (px0 == 10'd560) c560 = rgb0;
            if (px0 == 10'd700) c700 = rgb0;
        end
        total++;
        if (c79 !== x79) $display("FAIL rgb_x79 got=%h required=%h", c79, x79);
        else passed++;
        total++;
        if (c80 !== x80) $display("FAIL rgb_x80 got=%h required=%h", c80, x80);
        else passed++;
        total++;
        if (c560 !== x560) $display("FAIL rgb_x560 got=%h required=%h", c560, x560);
        else passed++;
        total++;
        if (c700 !== 12'h000) $display("FAIL rgb_blank got=%h required=000", c700);
        else passed++;
        total++;
        if (bad0 !== 0) $display("FAIL pattern_stream mismatches=%0d required 0", bad0);
        else passed++;
    endtask

    task automatic test_frame_timing();
        int n = 0, n_fs = 0, last_fs = 0, bad_int = 0, vs_low = 0, von_n = 0, von_out = 0;
        int vs_x = -1, vs_y = -1;
        logic prev_vs = 1'b1;
        bad1 = 0;
        while (!fs1 && n < 300) begin
            step(1'b0, 1'b0);
            if (g1 !== e1) bad1++;
            n++;
        end
        total++;
        if (n >= 300) $display("FAIL frame_sync_timeout cycles=%0d required <300", n);
        else passed++;
        for (int i = 1; i <= 2 * SH_T * SV_T; i++) begin
            step(1'b0, 1'b0);
            if (g1 !== e1) bad1++;
            if (fs1) begin
                n_fs++;
                if (i - last_fs != SH_T * SV_T) bad_int++;
                last_fs = i;
            end
            if (!vs1) vs_low++;
            if (prev_vs && !vs1 && vs_x < 0) begin vs_x = int'(px1); vs_y = int'(py1); end
            prev_vs = vs1;
            if (von1) von_n++;
            if (von1 && py1 >= 10'(SV_A)) von_out++;
        end
        total++;
        if (n_fs !== 2 || bad_int !== 0)
            $display("FAIL frame_period pulses=%0d bad_intervals=%0d required 2 and 0", n_fs, bad_int);
        else passed++;
        total++;
        if (vs_low !== 2 * SH_T * SV_S) $display("FAIL vsync_width low_cycles=%0d required %0d", vs_low, 2 * SH_T * SV_S);
        else passed++;
        total++;
        if (vs_x !== 0 || vs_y !== SV_A + SV_F)
            $display("FAIL vsync_start x=%0d y=%0d required 0 %0d", vs_x, vs_y, SV_A + SV_F);
        else passed++;
        total++;
        if (von_n !== 2 * SH_A * SV_A || von_out !== 0)
            $display("FAIL active_per_frame von=%0d outside=%0d required %0d and 0", von_n, von_out, 2 * SH_A * SV_A);
        else passed++;
        total++;
        if (bad1 !== 0) $display("FAIL frame_stream mismatches=%0d required 0", bad1);
        else passed++;
    endtask

    task automatic test_mid_frame_reset();
        int n = 0;
        bad0 = 0; bad1 = 0;
        while (!(px1 == 10'd5 && py1 == 10'd4) && n < 300) begin
            step(1'b0, 1'b0);
            if (g1 !== e1) bad1++;
            n++;
        end
        total++;
        if (n >= 300) $display("FAIL midreset_dut1_timeout cycles=%0d required <300", n);
        else passed++;
        step(1'b0, 1'b1);
        total++;
        if (g1 !== rst_out()) $display("FAIL midreset_dut1_hold got=%h required=%h", g1, rst_out());
        else passed++;
        step(1'b0, 1'b0);
        total++;
        if ({fs1, ls1, von1, px1, py1} !== {1'b1, 1'b1, 1'b1, 10'd0, 10'd0})
            $display("FAIL midreset_dut1_restart fs=%b ls=%b von=%b x=%0d y=%0d required 1 1 1 0 0",
                     fs1, ls1, von1, px1, py1);
        else passed++;
        n = 0;
        while (px0 != 10'd300 && n < 900) begin
            step(1'b0, 1'b0);
            if (g0 !== e0) bad0++;
            n++;
        end
        total++;
        if (n >= 900) $display("FAIL midreset_dut0_timeout cycles=%0d required <900", n);
        else passed++;
        step(1'b1, 1'b0);
        total++;
        if (g0 !== rst_out()) $display("FAIL midreset_dut0_hold got=%h required=%h", g0, rst_out());
        else passed++;
        step(1'b0, 1'b0);
        total++;
        if ({fs0, ls0, px0, py0} !== {1'b1, 1'b1, 10'd0, 10'd0})
            $display("FAIL midreset_dut0_restart fs=%b ls=%b x=%0d y=%0d required 1 1 0 0", fs0, ls0, px0, py0);
        else passed++;
        total++;
        if (bad0 !== 0 || bad1 !== 0)
            $display("FAIL midreset_stream mismatches=%0d/%0d required 0/0", bad0, bad1);
        else passed++;
    endtask

    initial begin
        rst0 = 1'b1;
        rst1 = 1'b1;
        @(negedge clk);
        test_reset();
        test_line_timing();
        test_pattern();
        test_frame_timing();
        test_mid_frame_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
